// File: rtl/pipelined_addsub_if.sv
// Bus bundle for pipelined_addsub: operand/control inputs towards the adder, result outputs back.
// The ovf signal exists only when PIPELINED_ADDSUB_OVF_EN is defined.
interface pipelined_addsub_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] y;
    logic             cout;
`ifdef PIPELINED_ADDSUB_OVF_EN
    logic             ovf;
`endif
    logic             out_valid;

    modport master (
        output en, in_valid, A, B, cin, sub,
        input  y, cout,
`ifdef PIPELINED_ADDSUB_OVF_EN
        input  ovf,
`endif
        input  out_valid
    );

    modport slave (
        input  en, in_valid, A, B, cin, sub,
        output y, cout,
`ifdef PIPELINED_ADDSUB_OVF_EN
        output ovf,
`endif
        output out_valid
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: one CW-bit chunk resolved per stage, carry registered between stages.
// Define PIPELINED_ADDSUB_OVF_EN to build the signed overflow flag and its register.
module pipelined_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    pipelined_addsub_if.slave  io_bus
);
    localparam int CW = WIDTH / STAGES;

    // Row k is the register bank after stage k; column j is operand/result chunk j.
    logic [CW-1:0] r_a [STAGES][STAGES];
    logic [CW-1:0] r_b [STAGES][STAGES];
    logic [CW-1:0] r_y [STAGES][STAGES];
    logic          r_c [STAGES];
    logic          r_v [STAGES];
`ifdef PIPELINED_ADDSUB_OVF_EN
    logic          r_ovf;
`endif

    logic [CW-1:0] w_a_chunk [STAGES];
    logic [CW-1:0] w_b_chunk [STAGES];
    logic          w_c0;
    logic [CW-1:0] w_a_op    [STAGES];
    logic [CW-1:0] w_b_op    [STAGES];
    logic [CW-1:0] w_sum     [STAGES];
    logic          w_c_out   [STAGES];

    function automatic logic [CW:0] ripple(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic c);
        logic [CW-1:0] s;
        logic          carry;
        carry = c;
        for (int i = 0; i < CW; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        return {carry, s};
    endfunction

    // Subtraction is A + ~B + 1, so cin is ignored when sub is set.
    always_comb begin
        w_c0 = io_bus.sub ? 1'b1 : io_bus.cin;
        for (int j = 0; j < STAGES; j++) begin
            w_a_chunk[j] = io_bus.A[j*CW +: CW];
            w_b_chunk[j] = io_bus.sub ? ~io_bus.B[j*CW +: CW] : io_bus.B[j*CW +: CW];
        end
        w_a_op[0] = w_a_chunk[0];
        w_b_op[0] = w_b_chunk[0];
        {w_c_out[0], w_sum[0]} = ripple(w_a_op[0], w_b_op[0], w_c0);
        for (int k = 1; k < STAGES; k++) begin
            w_a_op[k] = r_a[k-1][k];
            w_b_op[k] = r_b[k-1][k];
            {w_c_out[k], w_sum[k]} = ripple(w_a_op[k], w_b_op[k], r_c[k-1]);
        end
    end

    // NOTE: data and carry registers are cleared too, so y/cout read 0 right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                for (int j = 0; j < STAGES; j++) begin
                    r_a[k][j] <= '0;
                    r_b[k][j] <= '0;
                    r_y[k][j] <= '0;
                end
                r_c[k] <= 1'b0;
                r_v[k] <= 1'b0;
            end
`ifdef PIPELINED_ADDSUB_OVF_EN
            r_ovf <= 1'b0;
`endif
        end else if (io_bus.en) begin
            for (int j = 0; j < STAGES; j++) begin
                r_a[0][j] <= w_a_chunk[j];
                r_b[0][j] <= w_b_chunk[j];
                r_y[0][j] <= (j == 0) ? w_sum[0] : '0;
            end
            r_c[0] <= w_c_out[0];
            r_v[0] <= io_bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                for (int j = 0; j < STAGES; j++) begin
                    r_a[k][j] <= r_a[k-1][j];
                    r_b[k][j] <= r_b[k-1][j];
                    r_y[k][j] <= (j == k) ? w_sum[k] : r_y[k-1][j];
                end
                r_c[k] <= w_c_out[k];
                r_v[k] <= r_v[k-1];
            end
`ifdef PIPELINED_ADDSUB_OVF_EN
            // Sign bits sit in the top chunk, which only the last stage sees.
            r_ovf <= (w_a_op[STAGES-1][CW-1] == w_b_op[STAGES-1][CW-1]) &&
                     (w_sum[STAGES-1][CW-1] != w_a_op[STAGES-1][CW-1]);
`endif
        end
    end

    always_comb begin
        io_bus.y = '0;
        for (int j = 0; j < STAGES; j++) begin
            io_bus.y[j*CW +: CW] = r_y[STAGES-1][j];
        end
    end

    assign io_bus.cout      = r_c[STAGES-1];
    assign io_bus.out_valid = r_v[STAGES-1];
`ifdef PIPELINED_ADDSUB_OVF_EN
    assign io_bus.ovf       = r_ovf;
`endif
endmodule
